mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: SIZE, default 8, address width; memory depth is 2**SIZE words of 16 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  access request from port 0 (processor) and port 1 (loader/debug).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN=1.
REQ-006 addr0, addr1  input  SIZE each  word address; valid while reqN=1.
REQ-007 din0, din1  input  16 each  write data; valid while reqN=1 and weN=1.
REQ-008 gnt0, gnt1  output  1 each  access issued to RAM this cycle for that port.
REQ-009 rvalid0, rvalid1  output  1 each  read data valid on doutN this cycle.
REQ-010 dout0, dout1  output  16 each  read data returned to that port.
REQ-011 ram_we  output  1  RAM write enable.
REQ-012 ram_addr  output  SIZE  RAM address.
REQ-013 ram_din  output  16  RAM write data.
REQ-014 ram_dout  input  16  RAM read data; registered, valid the cycle after the address edge.
REQ-015 conflict_cnt  output  8  count of cycles in which a request waited while the other port was granted.

Function
REQ-016 FSM states: IDLE, GNT0, GNT1, held in a state register.
REQ-017 gntN SHALL be 1 exactly when the state is GNTN; gnt0 and gnt1 SHALL never both be 1.
REQ-018 In GNTN, ram_we/ram_addr/ram_din SHALL be driven combinationally from weN/addrN/dinN.
REQ-019 In IDLE, ram_we, ram_addr and ram_din SHALL all be 0.
REQ-020 Transitions from IDLE:
  - only req0 -> GNT0; only req1 -> GNT1; neither -> IDLE.
  - both -> the port not granted last (round-robin via last-winner register).
REQ-021 A request is consumed in the cycle its gnt is 1; reqN still high in that cycle SHALL NOT cause a repeat grant.
REQ-022 Transitions from GNTN: other port requesting -> GNT(other); otherwise -> IDLE.
  - Consequence: same-port back-to-back accesses are spaced by at least one IDLE cycle.
REQ-023 The last-winner register SHALL update to N on every entry to GNTN.
REQ-024 Requesters SHALL hold reqN/weN/addrN/dinN stable until gntN; behaviour when req is withdrawn early is undefined.
REQ-025 Read in GNTN (weN=0): in the next cycle rvalidN=1 and doutN=ram_dout, for exactly one cycle; a write SHALL produce no rvalid.
REQ-026 rvalid of a previous read SHALL coexist with a new grant in the same cycle (pipelined, no bubble).
REQ-027 Outside rvalidN cycles, doutN SHALL be 0.
REQ-028 conflict_cnt SHALL increment by 1 in each cycle in which req0=req1=1 and one port is not granted, or the ungranted port has req=1 while the other is granted.
  - conflict_cnt SHALL saturate at 255 (no wrap).
REQ-029 Latency: a request asserted in cycle t to an IDLE arbiter is granted in cycle t+1; read data returns in cycle t+2.

Reset
REQ-030 While rst=1 at posedge, the following SHALL take effect on the next cycle:
  - state=IDLE.
  - last-winner=1, so port 0 wins the first tie.
  - gnt0=gnt1=0, rvalid0=rvalid1=0, conflict_cnt=0.
  - ram_we=0, ram_addr=0, ram_din=0.
REQ-031 Reset asserted during GNTN SHALL abort that access: no rvalid follows and no further RAM write occurs after the reset edge.
REQ-032 Reset SHALL NOT alter RAM contents.

Verification
REQ-033 Port 0 only: write 16'h1234 @8'h10, then read @8'h10 -> gnt0 in cycles t+1 and t+3, rvalid0 at t+4 with dout0=16'h1234, conflict_cnt=0.
REQ-034 req0 and req1 both first asserted the cycle after reset -> gnt0 first, then gnt1; conflict_cnt=1.
REQ-035 Both ports hold continuous read requests for 10 cycles -> grants alternate 0,1,0,1 with no IDLE gap, and each rvalid follows its gnt by one cycle.
REQ-036 Port 1 writes 16'hBEEF @8'hFF while port 0 reads @8'hFF next -> port 0 receives 16'hBEEF; ram_addr=8'hFF during both grants (boundary address).
REQ-037 rst pulsed during GNT1 of a read -> no rvalid1, all outputs 0; after release, port 0 wins the first tie.
REQ-038 Hold both requests for 300 cycles -> conflict_cnt stops at 255.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared bus between the two requesters, the arbiter and the external
// synchronous RAM (registered read data, one cycle after the address edge).
interface mem_arbiter_if #(
    parameter int SIZE = 8
);
    logic            req0, req1;
    logic            we0, we1;
    logic [SIZE-1:0] addr0, addr1;
    logic [15:0]     din0, din1;
    logic            gnt0, gnt1;
    logic            rvalid0, rvalid1;
    logic [15:0]     dout0, dout1;
    logic            ram_we;
    logic [SIZE-1:0] ram_addr;
    logic [15:0]     ram_din;
    logic [15:0]     ram_dout;
    logic [7:0]      conflict_cnt;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, din0, din1, ram_dout,
        output gnt0, gnt1, rvalid0, rvalid1, dout0, dout1,
               ram_we, ram_addr, ram_din, conflict_cnt
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, din0, din1, ram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, dout0, dout1,
               ram_we, ram_addr, ram_din, conflict_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// One access per cycle; read data returns one cycle after its grant.

module mem_arbiter_port #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gnt_i,
    input  logic          we_i,
    input  logic [DW-1:0] ram_dout_i,
    output logic          rvalid_o,
    output logic [DW-1:0] dout_o
);
    logic rvalid_d, rvalid_q;

    always_comb begin
        rvalid_d = gnt_i & ~we_i;
    end

    always_ff @(posedge clk) begin
        if (rst) rvalid_q <= 1'b0;
        else     rvalid_q <= rvalid_d;
    end

    assign rvalid_o = rvalid_q;
    assign dout_o   = rvalid_q ? ram_dout_i : '0;
endmodule

module mem_arbiter #(
    parameter int SIZE = 8
) (
    input  logic        clk,
    input  logic        rst,
    mem_arbiter_if.slave bus
);
    localparam int NUM_PORTS = 2;
    localparam int DW        = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;     // 1 = port 1 won the most recent grant
    logic [7:0] cnt_q, cnt_d;

    logic [NUM_PORTS-1:0]           req, we, gnt, rvalid;
    logic [NUM_PORTS-1:0][SIZE-1:0] addr;
    logic [NUM_PORTS-1:0][DW-1:0]   din, dout;
    logic                           conflict;
    logic                           ram_we;
    logic [SIZE-1:0]                ram_addr;
    logic [DW-1:0]                  ram_din;

    assign req  = {bus.req1, bus.req0};
    assign we   = {bus.we1, bus.we0};
    assign addr = {bus.addr1, bus.addr0};
    assign din  = {bus.din1, bus.din0};

    // A granted request is consumed, so leaving GNTn only looks at the
    // other port; same-port repeats always pass through IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req[0] && req[1]) state_d = last_q ? GNT0 : GNT1;
                else if (req[0])      state_d = GNT0;
                else if (req[1])      state_d = GNT1;
            end
            GNT0:    state_d = req[1] ? GNT1 : IDLE;
            GNT1:    state_d = req[0] ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_d == GNT0)      last_d = 1'b0;
        else if (state_d == GNT1) last_d = 1'b1;
    end

    assign gnt[0] = (state_q == GNT0);
    assign gnt[1] = (state_q == GNT1);

    // A cycle counts when the port left waiting is still asking.
    assign conflict = (gnt[0] & req[1]) | (gnt[1] & req[0]);

    always_comb begin
        cnt_d = cnt_q;
        if (conflict && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            GNT0: begin
                ram_we   = we[0];
                ram_addr = addr[0];
                ram_din  = din[0];
            end
            GNT1: begin
                ram_we   = we[1];
                ram_addr = addr[1];
                ram_din  = din[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        mem_arbiter_port #(.DW(DW)) u_port (
            .clk        (clk),
            .rst        (rst),
            .gnt_i      (gnt[i]),
            .we_i       (we[i]),
            .ram_dout_i (bus.ram_dout),
            .rvalid_o   (rvalid[i]),
            .dout_o     (dout[i])
        );
    end

    assign bus.gnt0         = gnt[0];
    assign bus.gnt1         = gnt[1];
    assign bus.rvalid0      = rvalid[0];
    assign bus.rvalid1      = rvalid[1];
    assign bus.dout0        = dout[0];
    assign bus.dout1        = dout[1];
    assign bus.ram_we       = ram_we;
    assign bus.ram_addr     = ram_addr;
    assign bus.ram_din      = ram_din;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: a behavioural RAM on the bus, expected read
// data queued per port when each read is issued and popped on rvalid.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.SIZE(8)) bus ();
    mem_arbiter #(.SIZE(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return 16'hA500 ^ {a, a};
    endfunction

    // Synchronous RAM: read-before-write, data valid the cycle after the edge.
    bit [15:0] ram_mem [256];
    bit        ram_wr  [256];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            ram_mem[bus.ram_addr] <= bus.ram_din;
            ram_wr[bus.ram_addr]  <= 1'b1;
        end
        bus.ram_dout <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr] : init_val(bus.ram_addr);
    end

    logic [15:0] ref_mem [256];
    logic [15:0] exp0 [$];
    logic [15:0] exp1 [$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.din0 = 16'h0000;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.din1 = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 0000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1});
        end
        n_cmp++;
        if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== 25'h0) begin
            n_bad++; $display("FAIL reset_ram: got %h want 0", {bus.ram_we, bus.ram_addr, bus.ram_din});
        end
        n_cmp++;
        if ({bus.conflict_cnt, bus.dout0, bus.dout1} !== 40'h0) begin
            n_bad++; $display("FAIL reset_cnt_dout: got %h want 0", {bus.conflict_cnt, bus.dout0, bus.dout1});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
            n_bad++; $display("FAIL reset_idle: got %b want 00", {bus.gnt0, bus.gnt1});
        end
    endtask

    task automatic test_port0_rw();
        logic [15:0] e;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.din0 = 16'h1234;
        ref_mem[8'h10] = 16'h1234;
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.ram_din} !== {3'b101, 8'h10, 16'h1234}) begin
            n_bad++; $display("FAIL p0_wr_grant: got %h want %h",
                {bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.ram_din}, {3'b101, 8'h10, 16'h1234});
        end
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.rvalid0, bus.dout0} !== 18'h0) begin
            n_bad++; $display("FAIL p0_gap: got %h want 0", {bus.gnt0, bus.rvalid0, bus.dout0});
        end
        bus.we0 = 1'b0;
        exp0.push_back(ref_mem[8'h10]);
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.ram_we, bus.ram_addr} !== {2'b10, 8'h10}) begin
            n_bad++; $display("FAIL p0_rd_grant: got %h want %h", {bus.gnt0, bus.ram_we, bus.ram_addr}, {2'b10, 8'h10});
        end
        tick();
        e = exp0.pop_front();
        n_cmp++;
        if ({bus.rvalid0, bus.gnt0, bus.dout0} !== {2'b10, e}) begin
            n_bad++; $display("FAIL p0_rd_data: got %h want %h", {bus.rvalid0, bus.gnt0, bus.dout0}, {2'b10, e});
        end
        bus.req0 = 1'b0;
        tick();
        n_cmp++;
        if ({bus.rvalid0, bus.dout0, bus.conflict_cnt} !== 25'h0) begin
            n_bad++; $display("FAIL p0_after: got %h want 0", {bus.rvalid0, bus.dout0, bus.conflict_cnt});
        end
    endtask

    task automatic test_tie_after_reset();
        logic [15:0] e;
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h20;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h21;
        exp0.push_back(ref_mem[8'h20]);
        exp1.push_back(ref_mem[8'h21]);
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            n_bad++; $display("FAIL tie_first: got %b want 10", {bus.gnt0, bus.gnt1});
        end
        tick();
        e = exp0.pop_front();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.dout0} !== {3'b011, e}) begin
            n_bad++; $display("FAIL tie_second: got %h want %h", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.dout0}, {3'b011, e});
        end
        bus.req0 = 1'b0;
        tick();
        e = exp1.pop_front();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid1, bus.dout1} !== {3'b001, e}) begin
            n_bad++; $display("FAIL tie_p1_data: got %h want %h", {bus.gnt0, bus.gnt1, bus.rvalid1, bus.dout1}, {3'b001, e});
        end
        n_cmp++;
        if (bus.conflict_cnt !== 8'd1) begin
            n_bad++; $display("FAIL tie_conflict: got %0d want 1", bus.conflict_cnt);
        end
        bus.req1 = 1'b0;
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.conflict_cnt} !== {4'b0000, 8'd1}) begin
            n_bad++; $display("FAIL tie_no_repeat: got %h want %h",
                {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.conflict_cnt}, {4'b0000, 8'd1});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w0, w1;
        bit eg0, eg1, pg0, pg1;
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h40;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h80;
        exp0.push_back(ref_mem[8'h40]);
        exp1.push_back(ref_mem[8'h80]);
        pg0 = 1'b0; pg1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            eg0 = (k <= 10) && (k % 2 == 1);
            eg1 = (k <= 10) && (k % 2 == 0);
            n_cmp++;
            if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== {eg0, eg1, pg0, pg1}) begin
                n_bad++; $display("FAIL b2b_ctl cycle %0d: got %b want %b", k,
                    {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}, {eg0, eg1, pg0, pg1});
            end
            w0 = pg0 ? exp0.pop_front() : 16'h0000;
            w1 = pg1 ? exp1.pop_front() : 16'h0000;
            n_cmp++;
            if ({bus.dout0, bus.dout1} !== {w0, w1}) begin
                n_bad++; $display("FAIL b2b_dout cycle %0d: got %h want %h", k, {bus.dout0, bus.dout1}, {w0, w1});
            end
            if (pg0) begin
                if (k < 10) begin
                    bus.addr0 = bus.addr0 + 8'd1;
                    exp0.push_back(ref_mem[bus.addr0]);
                end else bus.req0 = 1'b0;
            end
            if (pg1) begin
                if (k < 10) begin
                    bus.addr1 = bus.addr1 + 8'd1;
                    exp1.push_back(ref_mem[bus.addr1]);
                end else bus.req1 = 1'b0;
            end
            pg0 = eg0; pg1 = eg1;
        end
        n_cmp++;
        if (bus.conflict_cnt !== 8'd9) begin
            n_bad++; $display("FAIL b2b_conflict: got %0d want 9", bus.conflict_cnt);
        end
    endtask

    task automatic test_boundary();
        logic [15:0] e;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'hFF; bus.din1 = 16'hBEEF;
        ref_mem[8'hFF] = 16'hBEEF;
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.ram_din} !== {3'b011, 8'hFF, 16'hBEEF}) begin
            n_bad++; $display("FAIL bnd_wr: got %h want %h",
                {bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.ram_din}, {3'b011, 8'hFF, 16'hBEEF});
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'hFF;
        exp0.push_back(ref_mem[8'hFF]);
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.rvalid1} !== {3'b100, 8'hFF, 1'b0}) begin
            n_bad++; $display("FAIL bnd_rd: got %h want %h",
                {bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.rvalid1}, {3'b100, 8'hFF, 1'b0});
        end
        bus.req1 = 1'b0;
        tick();
        e = exp0.pop_front();
        n_cmp++;
        if ({bus.rvalid0, bus.gnt0, bus.dout0} !== {2'b10, e}) begin
            n_bad++; $display("FAIL bnd_data: got %h want %h", {bus.rvalid0, bus.gnt0, bus.dout0}, {2'b10, e});
        end
        bus.req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        logic [15:0] e;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h30;
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            n_bad++; $display("FAIL abort_gnt1: got %b want 01", {bus.gnt0, bus.gnt1});
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_we, bus.ram_addr, bus.ram_din,
             bus.dout0, bus.dout1, bus.conflict_cnt} !== 69'h0) begin
            n_bad++; $display("FAIL abort_outputs: got %h want 0",
                {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_we, bus.ram_addr, bus.ram_din,
                 bus.dout0, bus.dout1, bus.conflict_cnt});
        end
        rst = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h31;
        bus.addr1 = 8'h32;
        exp0.push_back(ref_mem[8'h31]);
        exp1.push_back(ref_mem[8'h32]);
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid1} !== 3'b100) begin
            n_bad++; $display("FAIL abort_tie: got %b want 100", {bus.gnt0, bus.gnt1, bus.rvalid1});
        end
        tick();
        e = exp0.pop_front();
        n_cmp++;
        if ({bus.gnt1, bus.rvalid0, bus.dout0} !== {2'b11, e}) begin
            n_bad++; $display("FAIL abort_p0_data: got %h want %h", {bus.gnt1, bus.rvalid0, bus.dout0}, {2'b11, e});
        end
        bus.req0 = 1'b0;
        tick();
        e = exp1.pop_front();
        n_cmp++;
        if ({bus.rvalid1, bus.dout1} !== {1'b1, e}) begin
            n_bad++; $display("FAIL abort_p1_data: got %h want %h", {bus.rvalid1, bus.dout1}, {1'b1, e});
        end
        bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        int w;
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h50;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h51;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 100 || k == 255 || k == 256 || k == 257 || k == 300) begin
                w = (k - 1 > 255) ? 255 : k - 1;
                n_cmp++;
                if (bus.conflict_cnt !== 8'(w)) begin
                    n_bad++; $display("FAIL sat_cnt cycle %0d: got %0d want %0d", k, bus.conflict_cnt, w);
                end
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_port0_rw();
        test_tie_after_reset();
        test_back_to_back();
        test_boundary();
        test_reset_abort();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
